// File: rtl/bomb_game_ctrl.sv
`timescale 1ns/1ps
// bomb_game_ctrl: supervisor for a "defuse the bomb" puzzle game.
// Tracks a countdown, collects strikes from per-module wrong-move flags,
// resets offending modules one at a time, and decides whether the bomb is
// defused (every enabled module solved) or explodes (strike limit or timeout).
// Optional feature macro: BOMB_STRIKE_SPEEDUP_EN -- when defined, every strike
// halves the length of a countdown second (effective from the next second).
module bomb_game_ctrl #(
    parameter int NMOD        = 4,
    parameter int MAX_STRIKES = 3,
    parameter int TIME_S      = 300,
    parameter int TICKS_PER_S = 1000
) (
    input  logic            Clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NMOD-1:0] mod_en,
    input  logic [NMOD-1:0] mod_boom,
    input  logic [NMOD-1:0] mod_done,
    output logic [NMOD-1:0] mod_rst,
    output logic [1:0]      strikes,
    output logic [9:0]      sec_left,
    output logic            armed,
    output logic            defused,
    output logic            exploded,
    output logic            strike_beep
);

    localparam int              TW        = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
    localparam logic [TW-1:0]   WRAP_BASE = TW'(TICKS_PER_S - 1);
    localparam logic [9:0]      SEC_INIT  = 10'(TIME_S);
    localparam logic [NMOD-1:0] ONE_MOD   = NMOD'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_STRIKE,
        S_DEFUSED,
        S_EXPLODED
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [TW-1:0]   wrap_q, wrap_d;
    logic [9:0]      sec_q, sec_d;
    logic [1:0]      strikes_q, strikes_d;
    logic [NMOD-1:0] pending_q, pending_d;
    logic [NMOD-1:0] solved_q, solved_d;
    logic [NMOD-1:0] boom_q, boom_d;
    logic [NMOD-1:0] en_q, en_d;
    logic [NMOD-1:0] mod_rst_q, mod_rst_d;
    logic            beep_q, beep_d;
    logic            armed_q, armed_d;
    logic            defused_q, defused_d;
    logic            exploded_q, exploded_d;

    logic [NMOD-1:0] new_strike;
    logic [NMOD-1:0] done_hit;
    logic [NMOD-1:0] pend_all;
    logic [NMOD-1:0] serve_mask;
    logic [NMOD-1:0] solved_grow;
    logic            all_clear;
    logic            sec_wrap;
    logic            expire;
    logic [TW-1:0]   wrap_reload;

    // Per-module edge detection of wrong moves and qualification of solves.
    // Modules that are disabled or already solved can no longer earn strikes.
    generate
        for (genvar gi = 0; gi < NMOD; gi++) begin : g_mod
            assign new_strike[gi] = mod_boom[gi] & ~boom_q[gi] & en_q[gi] & ~solved_q[gi];
            assign done_hit[gi]   = mod_done[gi] & en_q[gi];
        end
    endgenerate

    // Pending strikes are served lowest index first; x & -x isolates that bit.
    assign pend_all    = pending_q | new_strike;
    assign serve_mask  = pend_all & (~pend_all + ONE_MOD);
    assign solved_grow = solved_q | done_hit;
    assign all_clear   = &(solved_grow | ~en_q);
    assign sec_wrap    = (tick_q == wrap_q);
    assign expire      = sec_wrap && (sec_q == 10'd1);

`ifdef BOMB_STRIKE_SPEEDUP_EN
    // Second length halves per committed strike, never shorter than one tick.
    logic [31:0] period_sh;
    assign period_sh   = 32'(TICKS_PER_S) >> strikes_q;
    assign wrap_reload = (period_sh == 32'd0) ? '0 : TW'(period_sh - 32'd1);
`else
    // Second length is constant for the whole game.
    assign wrap_reload = WRAP_BASE;
`endif

    // Next-state and next-output logic for the game FSM.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        wrap_d     = wrap_q;
        sec_d      = sec_q;
        strikes_d  = strikes_q;
        pending_d  = pending_q;
        solved_d   = solved_q;
        boom_d     = boom_q;
        en_d       = en_q;
        mod_rst_d  = '0;
        beep_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Track boom levels so a flag already high at arming is not an edge.
                boom_d    = mod_boom;
                tick_d    = '0;
                wrap_d    = WRAP_BASE;
                sec_d     = SEC_INIT;
                strikes_d = '0;
                pending_d = '0;
                solved_d  = '0;
                if (start) begin
                    state_d = S_ARMED;
                    en_d    = mod_en;
                end
            end

            S_ARMED, S_STRIKE: begin
                boom_d    = mod_boom;
                pending_d = pend_all;
                solved_d  = solved_grow;

                // Countdown keeps running during strike visits.
                if (sec_wrap) begin
                    tick_d = '0;
                    wrap_d = wrap_reload;
                    if (sec_q != 10'd0) begin
                        sec_d = sec_q - 10'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end

                if (state_q == S_STRIKE) begin
                    // Strike limit beats a full solve, which beats a timeout.
                    if (int'(strikes_q) >= MAX_STRIKES) begin
                        state_d = S_EXPLODED;
                    end else if (all_clear) begin
                        state_d = S_DEFUSED;
                    end else if (expire) begin
                        state_d = S_EXPLODED;
                    end else begin
                        state_d = S_ARMED;
                    end
                end else begin
                    if (all_clear) begin
                        state_d = S_DEFUSED;
                    end else if (expire) begin
                        state_d = S_EXPLODED;
                    end else if (|pend_all) begin
                        state_d   = S_STRIKE;
                        pending_d = pend_all & ~serve_mask;
                        strikes_d = strikes_q + 2'd1;
                        mod_rst_d = serve_mask;
                        beep_d    = 1'b1;
                    end
                end
            end

            default: begin
                // Terminal states hold everything until reset.
            end
        endcase

        if (state_d == S_IDLE) begin
            mod_rst_d = '1;
        end
        armed_d    = (state_d == S_ARMED) || (state_d == S_STRIKE);
        defused_d  = (state_d == S_DEFUSED);
        exploded_d = (state_d == S_EXPLODED);
    end

    // State, counters and registered outputs; reset returns to a fresh IDLE.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            wrap_q     <= WRAP_BASE;
            sec_q      <= SEC_INIT;
            strikes_q  <= '0;
            pending_q  <= '0;
            solved_q   <= '0;
            boom_q     <= '0;
            en_q       <= '0;
            mod_rst_q  <= '1;
            beep_q     <= 1'b0;
            armed_q    <= 1'b0;
            defused_q  <= 1'b0;
            exploded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            sec_q      <= sec_d;
            strikes_q  <= strikes_d;
            pending_q  <= pending_d;
            solved_q   <= solved_d;
            boom_q     <= boom_d;
            en_q       <= en_d;
            mod_rst_q  <= mod_rst_d;
            beep_q     <= beep_d;
            armed_q    <= armed_d;
            defused_q  <= defused_d;
            exploded_q <= exploded_d;
        end
    end

    assign mod_rst     = mod_rst_q;
    assign strikes     = strikes_q;
    assign sec_left    = sec_q;
    assign armed       = armed_q;
    assign defused     = defused_q;
    assign exploded    = exploded_q;
    assign strike_beep = beep_q;

endmodule

// File: doc/bomb_game_ctrl.md
BOMB_GAME_CTRL -- requirements
Module: bomb_game_ctrl

Interface
REQ-001 SHALL have parameter NMOD, default 4: number of puzzle modules supervised.
REQ-002 SHALL have parameter MAX_STRIKES, default 3: strike count that detonates.
REQ-003 SHALL have parameter TIME_S, default 300: countdown length in seconds.
REQ-004 SHALL have parameter TICKS_PER_S, default 1000: Clk cycles per second.
REQ-005 SHALL have ports:
- Clk  in  1  game clock, 1 kHz; one clock; all state on posedge Clk.
- rst  in  1  asynchronous active-high reset.
- start  in  1  level; arms the game from IDLE.
- mod_en  in  NMOD  modules taking part; sampled on IDLE->ARMED.
- mod_boom  in  NMOD  per-module wrong-move flag, level, sticky until that module is reset.
- mod_done  in  NMOD  per-module solved flag, level.
- mod_rst  out  NMOD  per-module reset pulse.
- strikes  out  2  current strike count.
- sec_left  out  10  seconds remaining.
- armed, defused, exploded  out  1  game state flags.
- strike_beep  out  1  one-cycle pulse per strike.

Function
REQ-006 SHALL implement FSM IDLE, ARMED, STRIKE, DEFUSED, EXPLODED; DEFUSED and EXPLODED are terminal until rst.
REQ-007 IDLE: sec_left=TIME_S, strikes=0, mod_rst all ones; start=1 -> ARMED next cycle, latching mod_en into en_q.
REQ-008 ARMED: tick counter counts 0..TICKS_PER_S-1; at wrap, sec_left decrements by 1.
REQ-009 sec_left SHALL never wrap below 0; the wrap that would take it from 1 to 0 sets sec_left=0 and enters EXPLODED.
REQ-010 Strike detection: new = mod_boom & ~boom_q & en_q & ~solved; set bits ORed into pending mask each cycle in ARMED.
REQ-011 Any pending bit -> STRIKE for exactly one cycle, serving the lowest-index pending module i: clear pending[i], mod_rst[i]=1, strike_beep=1, strikes+1.
REQ-012 STRIKE -> ARMED next cycle unless strikes reached MAX_STRIKES, then -> EXPLODED; remaining pending bits are served one per STRIKE visit.
REQ-013 Timer SHALL continue counting during STRIKE.
REQ-014 solved[i] SHALL set when mod_done[i] & en_q[i] in ARMED or STRIKE; never clears until rst.
REQ-015 When (solved | ~en_q) is all ones -> DEFUSED.
REQ-016 Same-cycle priority: strike reaching MAX_STRIKES > all solved > timer expiry; e.g. last solve and expiry in one cycle -> DEFUSED.
REQ-017 mod_en all zero at start -> DEFUSED on the cycle after entering ARMED.
REQ-018 Flags: armed=1 in ARMED/STRIKE; defused=1 only in DEFUSED; exploded=1 only in EXPLODED; exactly one or none asserted.
REQ-019 In DEFUSED/EXPLODED: counters frozen, mod_boom/mod_done ignored, mod_rst=0.

Reset
REQ-020 rst SHALL asynchronously force IDLE, sec_left=TIME_S, strikes=0, tick=0, pending=0, solved=0, boom_q=0, en_q=0, strike_beep=0, all flags 0, mod_rst all ones.
REQ-021 rst mid-game (any state) SHALL restore the values of REQ-020; no strike or solve is recorded from the reset cycle.

Configuration
REQ-022 Macro BOMB_STRIKE_SPEEDUP_EN defined: tick wrap value = (TICKS_PER_S >> strikes) - 1, so each strike doubles countdown rate; new rate takes effect at the next wrap.
REQ-023 Macro undefined: wrap value fixed at TICKS_PER_S - 1 regardless of strikes.

Verification
REQ-024 Timeout: rst, mod_en=4'b0011, start, no inputs -> sec_left hits 0 after 300000 cycles, exploded=1, strikes=0.
REQ-025 Strike serialization: mod_boom[2] and [0] rise same cycle -> STRIKE serves module 0 then 2 on consecutive visits, two beeps, strikes=2, mod_rst[0] then mod_rst[2].
REQ-026 Detonation: three separate boom edges on module 1 -> third STRIKE goes to EXPLODED, strikes=3, sec_left frozen.
REQ-027 Defuse: mod_en=4'b0101, assert mod_done[0], later mod_done[2] -> defused=1 next cycle; later mod_boom edges -> no beep.
REQ-028 Priority: last mod_done arrives the cycle sec_left 1->0 -> defused=1, exploded=0.
REQ-029 With BOMB_STRIKE_SPEEDUP_EN, one strike -> subsequent second periods 500 cycles; without macro -> 1000.
